subleq_ctrl: RTL



---
 rtl/subleq_pkg.sv | 21 ++
 rtl/subleq_alu.sv | 19 +
 rtl/subleq_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/subleq_pkg.sv
// Shared types and constants for the SUBLEQ control slice.
package subleq_pkg;

    localparam int DEF_WIDTH = 8;
    localparam logic [DEF_WIDTH-1:0] DEF_HALT_ADDR = '1;

    // Memory access direction as driven on mem_we.
    localparam logic ACC_RD = 1'b0;
    localparam logic ACC_WR = 1'b1;

    typedef enum logic [2:0] {
        FETCH_A = 3'd0,
        FETCH_B = 3'd1,
        FETCH_C = 3'd2,
        READ_A  = 3'd3,
        READ_B  = 3'd4,
        WRITE   = 3'd5,
        HALT    = 3'd6
    } state_e;

endpackage

// File: rtl/subleq_alu.sv
// SUBLEQ arithmetic: result = opb - opa (wrapping) and the <=0 branch flag.
import subleq_pkg::*;

module subleq_alu #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH-1:0] result_o,
    output logic             leq_o
);

    // Wrapped difference; sign bit of the wrapped result decides, no overflow fix-up.
    always_comb begin
        result_o = opb_i - opa_i;
        leq_o    = (result_o == '0) | result_o[WIDTH-1];
    end

endmodule

// File: rtl/subleq_ctrl.sv
// SUBLEQ instruction sequencer driving one shared req/ack memory port.
import subleq_pkg::*;

module subleq_ctrl #(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] HALT_ADDR = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [WIDTH-1:0] pc,
    output logic             halted,
    output logic             instr_done
);

    state_e           state_q;
    logic [WIDTH-1:0] pc_q, a_q, b_q, c_q, opa_q, opb_q;
    logic             req_q, we_q, halted_q, done_q;
    logic [WIDTH-1:0] addr_q, wdata_q;

    logic [WIDTH-1:0] alu_opb, alu_res;
    logic             alu_leq;
    logic [WIDTH-1:0] start_addr_d, next_pc_d;
    logic             halt_d;

    // During READ_B the ALU sees the incoming mem[B] so the write data is ready
    // on the cycle after the ack; everywhere else it uses the latched operand.
    subleq_alu #(.WIDTH(WIDTH)) u_alu (
        .opa_i    (opa_q),
        .opb_i    (alu_opb),
        .result_o (alu_res),
        .leq_o    (alu_leq)
    );

    // Operand mux, address of the current state's access, and branch decision.
    always_comb begin
        alu_opb   = (state_q == READ_B) ? mem_rdata : opb_q;
        next_pc_d = alu_leq ? c_q : pc_q + WIDTH'(3);
        halt_d    = alu_leq && (c_q == HALT_ADDR);
        case (state_q)
            FETCH_A: start_addr_d = pc_q;
            FETCH_B: start_addr_d = pc_q + WIDTH'(1);
            FETCH_C: start_addr_d = pc_q + WIDTH'(2);
            READ_A:  start_addr_d = a_q;
            default: start_addr_d = b_q;
        endcase
    end

    // Main FSM: on each acked access latch the data and present the next access
    // in the same step, giving back-to-back accesses on a zero-wait memory.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= FETCH_A;
            pc_q     <= RESET_PC;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= ACC_RD;
            addr_q   <= '0;
            wdata_q  <= '0;
            halted_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == HALT) begin
                req_q <= 1'b0;
                we_q  <= ACC_RD;
                if (start) begin
                    state_q  <= FETCH_A;
                    pc_q     <= RESET_PC;
                    halted_q <= 1'b0;
                end
            end else if (!req_q) begin
                // Entering a state with no access outstanding (after reset/start).
                req_q   <= 1'b1;
                addr_q  <= start_addr_d;
                we_q    <= (state_q == WRITE) ? ACC_WR : ACC_RD;
                wdata_q <= alu_res;
            end else if (mem_ack) begin
                case (state_q)
                    FETCH_A: begin
                        a_q     <= mem_rdata;
                        state_q <= FETCH_B;
                        addr_q  <= pc_q + WIDTH'(1);
                    end
                    FETCH_B: begin
                        b_q     <= mem_rdata;
                        state_q <= FETCH_C;
                        addr_q  <= pc_q + WIDTH'(2);
                    end
                    FETCH_C: begin
                        c_q     <= mem_rdata;
                        state_q <= READ_A;
                        addr_q  <= a_q;
                    end
                    READ_A: begin
                        opa_q   <= mem_rdata;
                        state_q <= READ_B;
                        addr_q  <= b_q;
                    end
                    READ_B: begin
                        opb_q   <= mem_rdata;
                        state_q <= WRITE;
                        addr_q  <= b_q;
                        we_q    <= ACC_WR;
                        wdata_q <= alu_res;
                    end
                    default: begin
                        // WRITE acked: instruction retires here.
                        done_q <= 1'b1;
                        we_q   <= ACC_RD;
                        if (halt_d) begin
                            state_q  <= HALT;
                            pc_q     <= HALT_ADDR;
                            halted_q <= 1'b1;
                            req_q    <= 1'b0;
                        end else begin
                            state_q <= FETCH_A;
                            pc_q    <= next_pc_d;
                            addr_q  <= next_pc_d;
                        end
                    end
                endcase
            end
        end
    end

    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign pc         = pc_q;
    assign halted     = halted_q;
    assign instr_done = done_q;

endmodule
